// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EXE/MEM destination shadows, raises stall/flush/freeze
// and selects operand forwarding. Define HAZARD_CTRL_FORWARD_EN to build the forwarding path.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        id_mem_r_en,
  input  logic        exe_b,
  input  logic        mem_ready,
  output logic        hazard,
  output logic        freeze,
  output logic        flush,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic [15:0] stall_cnt
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  exe_dest_r, mem_dest_r;
  logic        exe_wb_en_r, exe_mem_r_en_r, mem_wb_en_r;
  logic        a_exe_s, b_exe_s, a_mem_s, b_mem_s;
  logic        load_use_s, alu_use_s, mem_use_s;
  logic        hazard_raw_s, bubble_s;

  // Source matching, stall/flush decisions and FSM next state
  always_comb begin
    a_exe_s     = id_valid & exe_wb_en_r & (exe_dest_r == id_src1);
    b_exe_s     = id_valid & exe_wb_en_r & id_two_src & (exe_dest_r == id_src2);
    a_mem_s     = id_valid & mem_wb_en_r & (mem_dest_r == id_src1);
    b_mem_s     = id_valid & mem_wb_en_r & id_two_src & (mem_dest_r == id_src2);
    load_use_s  = (a_exe_s | b_exe_s) & exe_mem_r_en_r;
    alu_use_s   = (a_exe_s | b_exe_s) & ~exe_mem_r_en_r;
    mem_use_s   = a_mem_s | b_mem_s;
`ifdef HAZARD_CTRL_FORWARD_EN
    hazard_raw_s = load_use_s;
`else
    hazard_raw_s = load_use_s | alu_use_s | mem_use_s;
`endif
    freeze      = ~mem_ready;
    // Flush has priority over a stall; both are suppressed while frozen or in reset
    flush       = rst & mem_ready & exe_b;
    hazard      = rst & mem_ready & ~exe_b & hazard_raw_s;
    bubble_s    = hazard_raw_s | exe_b | ~id_valid;
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (!mem_ready) state_nxt_s = MEM_WAIT;
        else            state_nxt_s = RUN;
      end
      MEM_WAIT: begin
        if (mem_ready) state_nxt_s = RUN;
        else           state_nxt_s = MEM_WAIT;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= RUN;
    else      state_r <= state_nxt_s;
  end

  // EXE/MEM shadow slots advance only on non-freeze edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_dest_r     <= 4'd0;
      exe_wb_en_r    <= 1'b0;
      exe_mem_r_en_r <= 1'b0;
      mem_dest_r     <= 4'd0;
      mem_wb_en_r    <= 1'b0;
    end else if (mem_ready) begin
      mem_dest_r  <= exe_dest_r;
      mem_wb_en_r <= exe_wb_en_r;
      if (bubble_s) begin
        exe_dest_r     <= 4'd0;
        exe_wb_en_r    <= 1'b0;
        exe_mem_r_en_r <= 1'b0;
      end else begin
        exe_dest_r     <= id_dest;
        exe_wb_en_r    <= id_wb_en;
        exe_mem_r_en_r <= id_mem_r_en;
      end
    end else begin
      mem_dest_r     <= mem_dest_r;
      mem_wb_en_r    <= mem_wb_en_r;
      exe_dest_r     <= exe_dest_r;
      exe_wb_en_r    <= exe_wb_en_r;
      exe_mem_r_en_r <= exe_mem_r_en_r;
    end
  end

  // Saturating count of stalled or frozen cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          stall_cnt <= 16'd0;
    else if ((hazard | freeze) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    else                                               stall_cnt <= stall_cnt;
  end

`ifdef HAZARD_CTRL_FORWARD_EN
  logic [1:0] fwd_a_r, fwd_b_r, fwd_a_nxt_s, fwd_b_nxt_s;

  // Forward select for the instruction about to enter EXE; nearest producer wins
  always_comb begin
    fwd_a_nxt_s = 2'd0;
    fwd_b_nxt_s = 2'd0;
    if (bubble_s)     fwd_a_nxt_s = 2'd0;
    else if (a_exe_s) fwd_a_nxt_s = 2'd1;
    else if (a_mem_s) fwd_a_nxt_s = 2'd2;
    else              fwd_a_nxt_s = 2'd0;
    if (bubble_s)     fwd_b_nxt_s = 2'd0;
    else if (b_exe_s) fwd_b_nxt_s = 2'd1;
    else if (b_mem_s) fwd_b_nxt_s = 2'd2;
    else              fwd_b_nxt_s = 2'd0;
  end

  // Forward select registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_r <= 2'd0;
      fwd_b_r <= 2'd0;
    end else if (mem_ready) begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end else begin
      fwd_a_r <= fwd_a_r;
      fwd_b_r <= fwd_b_r;
    end
  end

  assign fwd_sel_a = fwd_a_r;
  assign fwd_sel_b = fwd_b_r;
`else
  assign fwd_sel_a = 2'd0;
  assign fwd_sel_b = 2'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a producer-list model of the EXE/MEM pipeline.
module tb_hazard_ctrl;

  logic        clk, rst;
  logic        id_valid, id_two_src, id_wb_en, id_mem_r_en, exe_b, mem_ready;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        hazard, freeze, flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_miss = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .exe_b(exe_b), .mem_ready(mem_ready),
    .hazard(hazard), .freeze(freeze), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: in-flight producers, index 0 = one stage ahead (EXE), 1 = two ahead (MEM)
  typedef struct {
    logic [3:0] dest;
    logic       wb;
    logic       ld;
  } prod_t;
  prod_t       pipe [2];
  logic [1:0]  m_fa, m_fb;
  logic [15:0] m_cnt;

  function automatic void model_zero();
    for (int i = 0; i < 2; i++) begin
      pipe[i].dest = 4'd0; pipe[i].wb = 1'b0; pipe[i].ld = 1'b0;
    end
    m_fa = 2'd0; m_fb = 2'd0; m_cnt = 16'd0;
  endfunction

  function automatic logic reads(input logic [3:0] r);
    return id_valid && (id_src1 == r || (id_two_src && id_src2 == r));
  endfunction

  function automatic logic must_stall();
    logic s;
    s = 1'b0;
`ifdef HAZARD_CTRL_FORWARD_EN
    s = pipe[0].wb && pipe[0].ld && reads(pipe[0].dest);
`else
    for (int i = 0; i < 2; i++) if (pipe[i].wb && reads(pipe[i].dest)) s = 1'b1;
`endif
    return s;
  endfunction

  // Distance to nearest producer of src: 1 = EXE, 2 = MEM, 0 = none
  function automatic logic [1:0] nearest(input logic [3:0] src, input logic used);
    for (int i = 0; i < 2; i++)
      if (used && id_valid && pipe[i].wb && pipe[i].dest == src) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic e_haz, e_flush;
    e_flush = rst && mem_ready && exe_b;
    e_haz   = rst && mem_ready && !exe_b && must_stall();
    chk("hazard", {15'd0, hazard}, {15'd0, e_haz});
    chk("flush", {15'd0, flush}, {15'd0, e_flush});
    chk("freeze", {15'd0, freeze}, {15'd0, !mem_ready});
    chk("fwd_sel_a", {14'd0, fwd_sel_a}, {14'd0, m_fa});
    chk("fwd_sel_b", {14'd0, fwd_sel_b}, {14'd0, m_fb});
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic model_step();
    logic st, bub;
    if (!rst) begin
      model_zero();
    end else begin
      st = must_stall();
      if ((!mem_ready || (!exe_b && st)) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (mem_ready) begin
        bub = st || exe_b || !id_valid;
`ifdef HAZARD_CTRL_FORWARD_EN
        m_fa = bub ? 2'd0 : nearest(id_src1, 1'b1);
        m_fb = bub ? 2'd0 : nearest(id_src2, id_two_src);
`endif
        pipe[1] = pipe[0];
        pipe[0].dest = bub ? 4'd0 : id_dest;
        pipe[0].wb   = bub ? 1'b0 : id_wb_en;
        pipe[0].ld   = bub ? 1'b0 : id_mem_r_en;
      end
    end
  endtask

  // One clock: compare at negedge, advance model, return just after the rising edge
  task automatic tick();
    if (!rst) model_zero();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic [3:0] dst,
                        input logic ld, input logic b, input logic rdy);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two; id_wb_en = wb;
    id_dest = dst; id_mem_r_en = ld; exe_b = b; mem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_zero();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_zero();
    #1;
    chk("reset_cnt", stall_cnt, 16'd0);
    chk("reset_haz", {15'd0, hazard}, 16'd0);
    tick();
    rst = 1'b1;

    // ALU producer r1 followed by a reader of r1
    do_reset();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1); tick();
    set_in(1'b1, 4'd1, 4'd9, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_CTRL_FORWARD_EN
    chk("s3_haz", {15'd0, hazard}, 16'd0); tick();
    chk("s3_fwd_a", {14'd0, fwd_sel_a}, 16'd1);
`else
    chk("s1_haz0", {15'd0, hazard}, 16'd1); tick();
    chk("s1_haz1", {15'd0, hazard}, 16'd1); tick();
    chk("s1_haz2", {15'd0, hazard}, 16'd0);
    chk("s1_cnt", stall_cnt, 16'd2);
`endif
    tick(); idle(); tick();

    // Load r2 followed by a reader of r2 on the second source
    do_reset();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1); tick();
    set_in(1'b1, 4'd7, 4'd2, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
    chk("s2_haz0", {15'd0, hazard}, 16'd1); tick();
`ifdef HAZARD_CTRL_FORWARD_EN
    chk("s2_haz1", {15'd0, hazard}, 16'd0); tick();
    chk("s2_fwd_b", {14'd0, fwd_sel_b}, 16'd2);
`else
    chk("s2_haz1", {15'd0, hazard}, 16'd1); tick();
    chk("s2_haz2", {15'd0, hazard}, 16'd0);
`endif
    idle(); tick();

    // Memory wait while a load-use stall is pending
    do_reset();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      chk("s4_freeze", {15'd0, freeze}, 16'd1);
      chk("s4_haz", {15'd0, hazard}, 16'd0);
      tick();
    end
    set_in(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    chk("s4_cnt", stall_cnt, 16'd3);
    chk("s4_resume", {15'd0, hazard}, 16'd1);
    tick(); idle(); tick(); tick();

    // Taken branch coinciding with a stall
    do_reset();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1); tick();
    set_in(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 1'b1);
    chk("s5_flush", {15'd0, flush}, 16'd1);
    chk("s5_haz", {15'd0, hazard}, 16'd0);
    tick();
    set_in(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_CTRL_FORWARD_EN
    chk("s5_bubble", {15'd0, hazard}, 16'd0);
`else
    chk("s5_bubble", {15'd0, hazard}, 16'd1);
`endif
    tick(); idle(); tick(); tick();

    // Reset in the middle of a stall
    do_reset();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("s6_cnt5", stall_cnt, 16'd5);
    rst = 1'b0;
    model_zero();
    #1;
    chk("s6_cnt0", stall_cnt, 16'd0);
    chk("s6_fwd", {12'd0, fwd_sel_a, fwd_sel_b}, 16'd0);
    chk("s6_freeze", {15'd0, freeze}, 16'd1);
    tick();
    rst = 1'b1;
    set_in(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("s6_nohaz", {15'd0, hazard}, 16'd0);
    tick();

    // Randomized traffic over a small register set including r15
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] r [4];
      r[0] = 4'd0; r[1] = 4'd1; r[2] = 4'd2; r[3] = 4'd15;
      set_in(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
             r[$urandom_range(0, 3)], r[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             r[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
      rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      #1;
      tick();
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
